dircc_avalon_st_packet_receiver: RTL and testbench

Avalon-ST sink that takes the byte stream produced by dircc_avalon_st_packet_sender and rebuilds one dircc_types_pkg::packet_t (240 bits) per Avalon-ST packet. It checks framing, optionally filters on destination hardware address, and holds the rebuilt packet in a one-entry output register with a valid/ready handshake to the device handler. It sits directly downstream of the sender, across the fabric.

---
 rtl/dircc_types_pkg.sv | 34 +++
 rtl/dircc_avalon_st_packet_receiver_if.sv | 24 ++
 rtl/dircc_sat_counter.sv | 23 ++
 rtl/dircc_avalon_st_packet_receiver.sv | 164 ++++++++++++++++
 tb/tb_dircc_avalon_st_packet_receiver.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dircc_types_pkg.sv
// Shared dircc types: address/packet layout, receiver FSM states and beat arithmetic.
package dircc_types_pkg;

    typedef logic [31:0] hw_addr_t;

    typedef struct packed {
        hw_addr_t    hw_addr;
        logic [15:0] sw_addr;
    } address_t;

    // Field order fixes the wire order: dest_addr occupies the MSBs sent on beat 0.
    typedef struct packed {
        address_t    dest_addr;
        address_t    src_addr;
        logic [7:0]  pkt_type;
        logic [7:0]  pin;
        logic [31:0] lamport;
        logic [95:0] data;
    } packet_t;

    localparam int unsigned PACKET_WIDTH = $bits(packet_t);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StHold,
        StDiscard
    } rx_state_t;

    function automatic int unsigned beats_for(int unsigned width);
        return (PACKET_WIDTH + width - 1) / width;
    endfunction

endpackage

// File: rtl/dircc_avalon_st_packet_receiver_if.sv
// Avalon-ST stream bundle between packet sender (master) and receiver (slave).
interface dircc_avalon_st_packet_receiver_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned EMPTY_WIDTH = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   ready;
    logic                   startofpacket;
    logic                   endofpacket;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (
        output data, valid, startofpacket, endofpacket, empty,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket, empty,
        output ready
    );

endinterface

// File: rtl/dircc_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module dircc_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dircc_avalon_st_packet_receiver.sv
// Avalon-ST sink rebuilding one packet_t per stream packet into a held output register.
// Define DIRCC_RX_ADDR_FILTER_EN to drop packets whose dest hw_addr differs from local_hw_addr.
module dircc_avalon_st_packet_receiver
    import dircc_types_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    dircc_avalon_st_packet_receiver_if.slave     asi_in,
    input  hw_addr_t                             local_hw_addr,
    output packet_t                              packet_out,
    output logic                                 packet_out_valid,
    input  logic                                 packet_out_ready,
    output logic [COUNT_WIDTH-1:0]               rx_count,
    output logic [COUNT_WIDTH-1:0]               err_count,
    output logic [COUNT_WIDTH-1:0]               filt_count
);

    localparam int unsigned BEATS       = beats_for(DATA_WIDTH);
    localparam int unsigned LAST_EMPTY  = (BEATS * DATA_WIDTH - PACKET_WIDTH) / 8;
    localparam int unsigned LAST_BITS   = DATA_WIDTH - 8 * LAST_EMPTY;
    localparam int unsigned ASM_WIDTH   = (BEATS - 1) * DATA_WIDTH;
    localparam int unsigned CNT_WIDTH   = $clog2(BEATS);
    localparam int unsigned EMPTY_WIDTH = $clog2(DATA_WIDTH / 8);

    localparam logic [CNT_WIDTH-1:0]   LastBeat  = CNT_WIDTH'(BEATS - 1);
    localparam logic [EMPTY_WIDTH-1:0] LastEmpty = EMPTY_WIDTH'(LAST_EMPTY);

    rx_state_t             state_q;
    logic [CNT_WIDTH-1:0]  beat_cnt_q;
    logic [ASM_WIDTH-1:0]  asm_q;
    packet_t               packet_q;
    logic                  valid_q;
    logic                  rx_inc_q;
    logic                  err_inc_q;
    logic                  filt_inc_q;

    logic                  accept;
    logic                  sop;
    logic                  eop;
    packet_t               packet_next;
    logic                  addr_match;

    assign asi_in.ready = (state_q != StHold);
    assign accept       = asi_in.valid && (state_q != StHold);
    assign sop          = asi_in.startofpacket;
    assign eop          = asi_in.endofpacket;

    // Earlier beats sit in asm_q; the final beat contributes only its non-empty upper bytes.
    assign packet_next = {asm_q, asi_in.data[DATA_WIDTH-1 -: LAST_BITS]};

`ifdef DIRCC_RX_ADDR_FILTER_EN
    assign addr_match = (packet_next.dest_addr.hw_addr == local_hw_addr);
`else
    logic unused_local_hw_addr;
    assign unused_local_hw_addr = ^local_hw_addr;
    assign addr_match = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            asm_q      <= '0;
            packet_q   <= '0;
            valid_q    <= 1'b0;
            rx_inc_q   <= 1'b0;
            err_inc_q  <= 1'b0;
            filt_inc_q <= 1'b0;
        end else begin
            rx_inc_q   <= 1'b0;
            err_inc_q  <= 1'b0;
            filt_inc_q <= 1'b0;

            if (accept) begin
                asm_q <= {asm_q[ASM_WIDTH-DATA_WIDTH-1:0], asi_in.data};
            end

            unique case (state_q)
                StIdle, StDiscard: begin
                    if (accept) begin
                        if (sop && !eop) begin
                            state_q    <= StCollect;
                            beat_cnt_q <= CNT_WIDTH'(1);
                        end else if (state_q == StIdle) begin
                            // Orphan beat, or a one-beat packet that can never be well-formed.
                            err_inc_q <= 1'b1;
                            state_q   <= eop ? StIdle : StDiscard;
                        end else if (eop) begin
                            state_q <= StIdle;
                        end
                    end
                end

                StCollect: begin
                    if (accept) begin
                        if (sop) begin
                            err_inc_q <= 1'b1;
                            if (eop) begin
                                state_q <= StIdle;
                            end else begin
                                beat_cnt_q <= CNT_WIDTH'(1);
                            end
                        end else if (eop) begin
                            if ((beat_cnt_q != LastBeat) || (asi_in.empty != LastEmpty)) begin
                                err_inc_q <= 1'b1;
                                state_q   <= StIdle;
                            end else if (addr_match) begin
                                packet_q <= packet_next;
                                valid_q  <= 1'b1;
                                state_q  <= StHold;
                            end else begin
                                filt_inc_q <= 1'b1;
                                state_q    <= StIdle;
                            end
                        end else if (beat_cnt_q == LastBeat) begin
                            err_inc_q <= 1'b1;
                            state_q   <= StDiscard;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end

                StHold: begin
                    if (packet_out_ready) begin
                        rx_inc_q <= 1'b1;
                        valid_q  <= 1'b0;
                        state_q  <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign packet_out       = packet_q;
    assign packet_out_valid = valid_q;

    dircc_sat_counter #(.WIDTH(COUNT_WIDTH)) u_rx_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rx_inc_q),
        .count   (rx_count)
    );

    dircc_sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc_q),
        .count   (err_count)
    );

    dircc_sat_counter #(.WIDTH(COUNT_WIDTH)) u_filt_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (filt_inc_q),
        .count   (filt_count)
    );

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// Bench for the Avalon-ST packet receiver at 32-bit data with narrow 4-bit counters.
module tb_dircc_avalon_st_packet_receiver;
    import dircc_types_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    hw_addr_t       local_hw_addr;
    packet_t        packet_out;
    logic           packet_out_valid;
    logic           packet_out_ready;
    logic [CW-1:0]  rx_count;
    logic [CW-1:0]  err_count;
    logic [CW-1:0]  filt_count;

    dircc_avalon_st_packet_receiver_if #(.DATA_WIDTH(DW)) asi ();

    dircc_avalon_st_packet_receiver #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .asi_in           (asi),
        .local_hw_addr    (local_hw_addr),
        .packet_out       (packet_out),
        .packet_out_valid (packet_out_valid),
        .packet_out_ready (packet_out_ready),
        .rx_count         (rx_count),
        .err_count        (err_count),
        .filt_count       (filt_count)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      passes = 0;
    int      exp_rx = 0;
    int      exp_err = 0;
    int      exp_filt = 0;
    packet_t exp_q[$];
    packet_t rcv_q[$];

    always @(posedge clk) begin
        if (reset_n && packet_out_valid && packet_out_ready) rcv_q.push_back(packet_out);
    end

    function automatic logic [CW-1:0] sat(int n);
        return (n > 15) ? 4'd15 : CW'(n);
    endfunction

    function automatic packet_t rand_pkt(hw_addr_t dest);
        logic [239:0] raw;
        packet_t p;
        for (int i = 0; i < 8; i++) raw[i*30 +: 30] = 30'($urandom);
        p = raw;
        p.dest_addr.hw_addr = dest;
        return p;
    endfunction

    // Beat k carries packet bits [239-32k -: 32]; bits below bit 0 are don't-care padding.
    function automatic logic [31:0] beat_of(packet_t p, int k);
        logic [255:0] pad;
        pad = {p, 16'($urandom)};
        return pad[255 - 32*k -: 32];
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit s, input bit e, input logic [1:0] emp);
        bit ok;
        asi.data = d;
        asi.valid = 1'b1;
        asi.startofpacket = s;
        asi.endofpacket = e;
        asi.empty = emp;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (asi.ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            $display("FAIL beat_timeout: asi_in_ready stayed %b, required 1 within 200 cycles",
                     asi.ready);
        end
        @(posedge clk);
        @(negedge clk);
        asi.valid = 1'b0;
        asi.data = $urandom;
        asi.startofpacket = 1'($urandom);
        asi.endofpacket = 1'($urandom);
        asi.empty = 2'($urandom);
    endtask

    task automatic send_packet(input packet_t p);
        for (int k = 0; k < 8; k++)
            send_beat(beat_of(p, k), k == 0, k == 7, (k == 7) ? 2'd2 : 2'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && rcv_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (asi.ready !== 1'b1)
            $display("FAIL reset_ready: got %b, expected 1", asi.ready); else passes++;
        checks++; if (packet_out_valid !== 1'b0)
            $display("FAIL reset_valid: got %b, expected 0", packet_out_valid); else passes++;
        checks++; if (packet_out !== '0)
            $display("FAIL reset_packet: got %h, expected 0", packet_out); else passes++;
        checks++; if ({rx_count, err_count, filt_count} !== '0)
            $display("FAIL reset_counters: got %h, expected 0", {rx_count, err_count, filt_count});
        else passes++;
    endtask

    task automatic test_single();
        packet_t p;
        p = rand_pkt(32'h0000_0001);
        p.data = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
        packet_out_ready = 1'b1;
        send_packet(p);
        exp_q.push_back(p);
        exp_rx++;
        checks++; if (packet_out_valid !== 1'b1)
            $display("FAIL single_valid_rise: got %b, expected 1", packet_out_valid); else passes++;
        checks++; if (packet_out !== p)
            $display("FAIL single_packet: got %h, expected %h", packet_out, p); else passes++;
        @(negedge clk);
        checks++; if (packet_out_valid !== 1'b0)
            $display("FAIL single_valid_pulse: got %b, expected 0", packet_out_valid); else passes++;
        drain();
        checks++; if (rcv_q.size() != exp_q.size())
            $display("FAIL single_deliveries: got %0d, expected %0d", rcv_q.size(), exp_q.size());
        else passes++;
        rcv_q.delete(); exp_q.delete();
        checks++; if (rx_count !== sat(exp_rx))
            $display("FAIL single_rx_count: got %0d, expected %0d", rx_count, sat(exp_rx));
        else passes++;
    endtask

    task automatic test_backpressure();
        packet_t p1, p2;
        bit      hold_ok;
        p1 = rand_pkt(local_hw_addr);
        p2 = rand_pkt(local_hw_addr);
        packet_out_ready = 1'b0;
        send_packet(p1);
        hold_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (asi.ready !== 1'b0 || packet_out !== p1 || packet_out_valid !== 1'b1) hold_ok = 0;
        end
        checks++; if (!hold_ok)
            $display("FAIL bp_hold: held output or ready changed, got %h, expected %h",
                     packet_out, p1);
        else passes++;
        fork
            send_packet(p2);
            begin
                repeat (5) @(negedge clk);
                checks++; if (rcv_q.size() != 0)
                    $display("FAIL bp_early_delivery: got %0d, expected 0", rcv_q.size());
                else passes++;
                packet_out_ready = 1'b1;
            end
        join
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_rx += 2;
        drain();
        checks++; if (rcv_q.size() != exp_q.size())
            $display("FAIL bp_deliveries: got %0d, expected %0d", rcv_q.size(), exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i])
                $display("FAIL bp_packet%0d: got %h, expected %h", i, rcv_q[i], exp_q[i]);
            else passes++;
        end
        rcv_q.delete(); exp_q.delete();
        checks++; if (rx_count !== sat(exp_rx))
            $display("FAIL bp_rx_count: got %0d, expected %0d", rx_count, sat(exp_rx));
        else passes++;
    endtask

    // One malformed frame followed by a good packet; kind selects the framing fault.
    task automatic test_bad_frame(input string name, input int kind);
        packet_t junk, p;
        junk = rand_pkt(local_hw_addr);
        p = rand_pkt(local_hw_addr);
        case (kind)
            0: for (int k = 0; k <= 5; k++) send_beat(beat_of(junk, k), k == 0, k == 5, 2'd2);
            1: for (int k = 0; k <= 2; k++) send_beat(beat_of(junk, k), k == 0, 1'b0, 2'd0);
            default: for (int k = 0; k <= 9; k++)
                send_beat($urandom, k == 0, k == 9, 2'd2);
        endcase
        exp_err++;
        checks++; if (kind != 1 && packet_out_valid !== 1'b0)
            $display("FAIL %s_no_valid: got %b, expected 0", name, packet_out_valid);
        else passes++;
        send_packet(p);
        exp_q.push_back(p);
        exp_rx++;
        drain();
        checks++; if (rcv_q.size() != 1)
            $display("FAIL %s_deliveries: got %0d, expected 1", name, rcv_q.size());
        else passes++;
        checks++; if (rcv_q.size() > 0 && rcv_q[0] !== p)
            $display("FAIL %s_packet: got %h, expected %h", name, rcv_q[0], p);
        else passes++;
        rcv_q.delete(); exp_q.delete();
        checks++; if (err_count !== sat(exp_err))
            $display("FAIL %s_err_count: got %0d, expected %0d", name, err_count, sat(exp_err));
        else passes++;
    endtask

    task automatic test_random();
        bit done = 0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    packet_t p;
                    int      kind, cut;
                    p = rand_pkt(local_hw_addr);
                    kind = $urandom_range(0, 4);
                    case (kind)
                        0: begin
                            send_packet(p);
                            exp_q.push_back(p);
                            exp_rx++;
                        end
                        1: begin
                            cut = $urandom_range(1, 6);
                            for (int k = 0; k <= cut; k++)
                                send_beat(beat_of(p, k), k == 0, k == cut, 2'd2);
                            exp_err++;
                        end
                        2: begin
                            for (int k = 0; k < 8; k++)
                                send_beat(beat_of(p, k), k == 0, k == 7,
                                          (k == 7) ? 2'(3 * $urandom_range(0, 1)) : 2'd0);
                            exp_err++;
                        end
                        3: begin
                            send_beat($urandom, 1'b0, 1'b1, 2'($urandom));
                            exp_err++;
                        end
                        default: begin
                            cut = 8 + $urandom_range(0, 2);
                            for (int k = 0; k <= cut; k++)
                                send_beat($urandom, k == 0, k == cut, 2'd2);
                            exp_err++;
                        end
                    endcase
                end
                done = 1;
            end
            while (!done) begin
                @(negedge clk);
                packet_out_ready = 1'($urandom);
            end
        join
        packet_out_ready = 1'b1;
        drain();
        checks++; if (rcv_q.size() != exp_q.size())
            $display("FAIL rand_deliveries: got %0d, expected %0d", rcv_q.size(), exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i])
                $display("FAIL rand_packet%0d: got %h, expected %h", i, rcv_q[i], exp_q[i]);
            else passes++;
        end
        rcv_q.delete(); exp_q.delete();
        checks++; if (rx_count !== sat(exp_rx))
            $display("FAIL rand_rx_count: got %0d, expected %0d", rx_count, sat(exp_rx));
        else passes++;
        checks++; if (err_count !== sat(exp_err))
            $display("FAIL rand_err_count: got %0d, expected %0d", err_count, sat(exp_err));
        else passes++;
        checks++; if (filt_count !== sat(exp_filt))
            $display("FAIL rand_filt_count: got %0d, expected %0d", filt_count, sat(exp_filt));
        else passes++;
    endtask

`ifdef DIRCC_RX_ADDR_FILTER_EN
    task automatic test_filter();
        packet_t p[3];
        int      rx0, filt0;
        local_hw_addr = 32'd5;
        rx0 = exp_rx;
        filt0 = exp_filt;
        p[0] = rand_pkt(32'd5);
        p[1] = rand_pkt(32'd6);
        p[2] = rand_pkt(32'd5);
        for (int i = 0; i < 3; i++) begin
            send_packet(p[i]);
            if (p[i].dest_addr.hw_addr == local_hw_addr) begin
                exp_q.push_back(p[i]);
                exp_rx++;
            end else begin
                exp_filt++;
            end
        end
        drain();
        checks++; if (rcv_q.size() != 2)
            $display("FAIL filt_deliveries: got %0d, expected 2", rcv_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i])
                $display("FAIL filt_packet%0d: got %h, expected %h", i, rcv_q[i], exp_q[i]);
            else passes++;
        end
        rcv_q.delete(); exp_q.delete();
        checks++; if (filt_count !== sat(exp_filt) || exp_filt != filt0 + 1 || exp_rx != rx0 + 2)
            $display("FAIL filt_count: got %0d, expected %0d", filt_count, sat(exp_filt));
        else passes++;
    endtask
`endif

    task automatic test_reset_mid();
        packet_t p;
        p = rand_pkt(local_hw_addr);
        for (int k = 0; k < 4; k++) send_beat(beat_of(p, k), k == 0, 1'b0, 2'd0);
        asi.data = beat_of(p, 4);
        asi.valid = 1'b1;
        asi.startofpacket = 1'b0;
        asi.endofpacket = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (asi.ready !== 1'b1)
            $display("FAIL midrst_ready: got %b, expected 1", asi.ready); else passes++;
        checks++; if (packet_out_valid !== 1'b0 || packet_out !== '0)
            $display("FAIL midrst_packet: got %b/%h, expected 0/0", packet_out_valid, packet_out);
        else passes++;
        checks++; if ({rx_count, err_count, filt_count} !== '0)
            $display("FAIL midrst_counters: got %h, expected 0", {rx_count, err_count, filt_count});
        else passes++;
        @(negedge clk);
        asi.valid = 1'b0;
        reset_n = 1'b1;
        exp_rx = 0; exp_err = 0; exp_filt = 0;
        @(negedge clk);
        p = rand_pkt(local_hw_addr);
        send_packet(p);
        exp_q.push_back(p);
        exp_rx++;
        drain();
        checks++; if (rcv_q.size() != 1 || rcv_q[0] !== p)
            $display("FAIL midrst_after: got %0d packets, expected 1 matching", rcv_q.size());
        else passes++;
        rcv_q.delete(); exp_q.delete();
        checks++; if (rx_count !== sat(exp_rx) || err_count !== sat(exp_err))
            $display("FAIL midrst_counts: got %0d/%0d, expected %0d/%0d",
                     rx_count, err_count, sat(exp_rx), sat(exp_err));
        else passes++;
    endtask

    initial begin
        reset_n = 1'b0;
        local_hw_addr = 32'h0000_0001;
        packet_out_ready = 1'b1;
        asi.data = '0;
        asi.valid = 1'b0;
        asi.startofpacket = 1'b0;
        asi.endofpacket = 1'b0;
        asi.empty = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_bad_frame("early_eop", 0);
        test_bad_frame("resop", 1);
        test_bad_frame("no_eop", 2);
        test_random();
`ifdef DIRCC_RX_ADDR_FILTER_EN
        test_filter();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier",
                 $time);
        $fatal(1);
    end

endmodule
